// File: rtl/systolic_out_collector.sv
// systolic_out_collector
// Collects row-aligned sum vectors from the systolic array, accumulates them
// across K-tiles in a SYSTOLIC_WIDTH x SYSTOLIC_WIDTH buffer, and drains the
// finished tile row by row over a valid/ready output.
module systolic_out_collector #(
    parameter int SYSTOLIC_WIDTH = 4,
    parameter int SUM_WIDTH      = 16,
    parameter int ACC_WIDTH      = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clear,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [SYSTOLIC_WIDTH*SUM_WIDTH-1:0] sum_in,
    input  logic                                tile_last,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [SYSTOLIC_WIDTH*ACC_WIDTH-1:0] out_data,
    output logic [$clog2(SYSTOLIC_WIDTH)-1:0]   out_row,
    output logic                                busy
);

    localparam int              CW       = $clog2(SYSTOLIC_WIDTH);
    localparam logic [CW-1:0]   LAST_ROW = CW'(SYSTOLIC_WIDTH - 1);

    typedef enum logic {
        S_FILL,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [CW-1:0]       r_row_cnt;
    logic [CW-1:0]       r_drain_cnt;
    logic                r_first_tile;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [ACC_WIDTH-1:0] r_buf [SYSTOLIC_WIDTH][SYSTOLIC_WIDTH];

    logic                w_accept;
    logic                w_out_fire;
    logic                w_row_end;
    logic                w_drain_end;
    logic [ACC_WIDTH-1:0] w_lane_ext [SYSTOLIC_WIDTH];

    assign w_accept    = in_valid && r_in_ready;
    assign w_out_fire  = r_out_valid && out_ready;
    assign w_row_end   = (r_row_cnt == LAST_ROW);
    assign w_drain_end = (r_drain_cnt == LAST_ROW);

    // Sign-extend each incoming lane to the accumulator width.
    // NOTE: every lane is assigned on every evaluation, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < SYSTOLIC_WIDTH; k++) begin
            w_lane_ext[k] = ACC_WIDTH'($signed(sum_in[k*SUM_WIDTH +: SUM_WIDTH]));
        end
    end

    // Control FSM: row/drain counters, first-tile flag and registered handshakes.
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FILL;
            r_row_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_first_tile <= 1'b1;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else if (clear) begin
            r_state      <= S_FILL;
            r_row_cnt    <= '0;
            r_drain_cnt  <= '0;
            r_first_tile <= 1'b1;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        if (w_row_end) begin
                            r_row_cnt <= '0;
                            if (tile_last) begin
                                r_state     <= S_DRAIN;
                                r_in_ready  <= 1'b0;
                                r_out_valid <= 1'b1;
                            end else begin
                                r_first_tile <= 1'b0;
                            end
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_fire) begin
                        if (w_drain_end) begin
                            r_drain_cnt  <= '0;
                            r_first_tile <= 1'b1;
                            r_state      <= S_FILL;
                            r_in_ready   <= 1'b1;
                            r_out_valid  <= 1'b0;
                        end else begin
                            r_drain_cnt <= r_drain_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state     <= S_FILL;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Tile buffer: overwrite on the first K-tile, wrap-around accumulate after.
    // NOTE: this buffer is reset because row 0 is visible on out_data straight
    // out of reset; clear leaves it alone and relies on first_tile to overwrite.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < SYSTOLIC_WIDTH; r++) begin
                for (int k = 0; k < SYSTOLIC_WIDTH; k++) begin
                    r_buf[r][k] <= '0;
                end
            end
        end else if (!clear && w_accept) begin
            for (int k = 0; k < SYSTOLIC_WIDTH; k++) begin
                if (r_first_tile) begin
                    r_buf[r_row_cnt][k] <= w_lane_ext[k];
                end else begin
                    r_buf[r_row_cnt][k] <= r_buf[r_row_cnt][k] + w_lane_ext[k];
                end
            end
        end
    end

    // Output row is selected purely from buffer registers by the drain counter.
    always_comb begin
        for (int k = 0; k < SYSTOLIC_WIDTH; k++) begin
            out_data[k*ACC_WIDTH +: ACC_WIDTH] = r_buf[r_drain_cnt][k];
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_row   = r_drain_cnt;
    assign busy      = (r_state == S_DRAIN) || (r_row_cnt != '0) || !r_first_tile;

endmodule
